instr_fetch: RTL and testbench

- PC-generation and IF/ID capture stage sitting directly upstream of the instruction memory.
- Drives the memory address and read enable each cycle, then registers the returned instruction into the IF/ID pipeline register.
- Handles pipeline stall, branch/jump redirect (flush), and HLT detection so that the core stops fetching once a halt is fetched.
- The instruction memory latches on the falling clock edge. The word addressed during a cycle is therefore stable at its output before the next rising edge.

---
 rtl/instr_fetch.sv | 78 +++++++
 tb/tb_instr_fetch.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: generates the PC for the instruction memory and captures the
// returned word into the IF/ID register, with stall, flush and halt handling.
module instr_fetch #(
  parameter logic [3:0]  HLT_OP    = 4'hF,
  parameter logic [15:0] NOP_INSTR = 16'hB000,
  parameter logic [15:0] RST_PC    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] branch_tgt,
  input  logic [15:0] im_instr,
  output logic [15:0] im_addr,
  output logic        im_rd_en,
  output logic [15:0] instr_IF_ID,
  output logic [15:0] pc_IF_ID,
  output logic        vld_IF_ID,
  output logic        hlt_fetched
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pcIfId_q, pcIfId_d;
  logic        vld_q, vld_d;

  assign im_addr     = pc_q;
  assign im_rd_en    = !rst && !stall && (state_q == RUN);
  assign instr_IF_ID = instr_q;
  assign pc_IF_ID    = pcIfId_q;
  assign vld_IF_ID   = vld_q;
  assign hlt_fetched = (state_q == HALTED);

  // Flush wins over stall and over a HLT arriving in the same cycle, so a
  // halt fetched down a mispredicted path never stops the core.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcIfId_d = pcIfId_q;
    vld_d    = vld_q;
    if (flush) begin
      pc_d    = branch_tgt;
      instr_d = NOP_INSTR;
      vld_d   = 1'b0;
      state_d = RUN;
    end else if (!stall && state_q == RUN) begin
      instr_d  = im_instr;
      pcIfId_d = pc_q + 16'd1;
      vld_d    = 1'b1;
      if (im_instr[15:12] == HLT_OP) begin
        state_d = HALTED;
      end else begin
        pc_d = pc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RST_PC;
      instr_q  <= NOP_INSTR;
      pcIfId_q <= 16'h0000;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcIfId_q <= pcIfId_d;
      vld_q    <= vld_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a vector table drives each cycle, registered results
// go through a scoreboard queue and are compared after the following edge.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [15:0] branch_tgt, im_instr;
  logic [15:0] im_addr, instr_IF_ID, pc_IF_ID;
  logic        im_rd_en, vld_IF_ID, hlt_fetched;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst, stall, flush;
    logic [15:0] tgt, instr;
    logic [15:0] expAddr;
    logic        expRd;
    logic [15:0] expInstr, expPc;
    logic        expVld, expHlt;
  } vec_t;

  typedef struct {
    logic [15:0] instr, pc;
    logic        vld, hlt;
  } post_t;

  vec_t  vecs[$];
  post_t sbQ[$];

  instr_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_tgt(branch_tgt), .im_instr(im_instr),
    .im_addr(im_addr), .im_rd_en(im_rd_en),
    .instr_IF_ID(instr_IF_ID), .pc_IF_ID(pc_IF_ID),
    .vld_IF_ID(vld_IF_ID), .hlt_fetched(hlt_fetched)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic r, logic s, logic f, logic [15:0] tgt,
                              logic [15:0] ins, logic [15:0] ea, logic er,
                              logic [15:0] ei, logic [15:0] ep, logic ev, logic eh);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.tgt = tgt; v.instr = ins;
    v.expAddr = ea; v.expRd = er;
    v.expInstr = ei; v.expPc = ep; v.expVld = ev; v.expHlt = eh;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkPost();
    post_t e;
    if (sbQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sbQ.pop_front();
    checkOutput("instr_IF_ID", instr_IF_ID, e.instr);
    checkOutput("pc_IF_ID", pc_IF_ID, e.pc);
    checkOutput("vld_IF_ID", {15'd0, vld_IF_ID}, {15'd0, e.vld});
    checkOutput("hlt_fetched", {15'd0, hlt_fetched}, {15'd0, e.hlt});
  endtask

  // Drive one cycle: inputs set after the falling edge, combinational outputs
  // checked before the rising edge, registered outputs checked just after it.
  task automatic applyStimulus(input vec_t v);
    post_t p;
    @(negedge clk);
    rst = v.rst; stall = v.stall; flush = v.flush;
    branch_tgt = v.tgt; im_instr = v.instr;
    #1;
    checkOutput("im_addr", im_addr, v.expAddr);
    checkOutput("im_rd_en", {15'd0, im_rd_en}, {15'd0, v.expRd});
    p.instr = v.expInstr; p.pc = v.expPc; p.vld = v.expVld; p.hlt = v.expHlt;
    sbQ.push_back(p);
    @(posedge clk);
    #1;
    checkPost();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    branch_tgt = 16'h0000; im_instr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_im_addr", im_addr, 16'h0000);
    checkOutput("reset_rd_en", {15'd0, im_rd_en}, 16'h0000);
    checkOutput("reset_instr", instr_IF_ID, 16'hB000);
    checkOutput("reset_pc_IF_ID", pc_IF_ID, 16'h0000);
    checkOutput("reset_vld", {15'd0, vld_IF_ID}, 16'h0000);
    checkOutput("reset_hlt", {15'd0, hlt_fetched}, 16'h0000);

    //              rst stall flush tgt      instr    addr     rd  instr    pcId     v  h
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h1234, 16'h0000, 1, 16'h1234, 16'h0001, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h2345, 16'h0001, 1, 16'h2345, 16'h0002, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h3456, 16'h0002, 1, 16'h3456, 16'h0003, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h4000, 16'h0003, 1, 16'h4000, 16'h0004, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h5000, 16'h0004, 1, 16'h5000, 16'h0005, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h5000, 16'h0005, 0, 16'h5000, 16'h0005, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h5000, 16'h0005, 0, 16'h5000, 16'h0005, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h6000, 16'h0005, 1, 16'h6000, 16'h0006, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h7000, 16'h0006, 1, 16'h7000, 16'h0007, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'hF000, 16'h0007, 1, 16'hF000, 16'h0008, 1, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'hF000, 16'h0007, 0, 16'hF000, 16'h0008, 1, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'hF000, 16'h0007, 0, 16'hF000, 16'h0008, 1, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0010, 16'hF000, 16'h0007, 0, 16'hB000, 16'h0008, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'hA000, 16'h0010, 1, 16'hA000, 16'h0011, 1, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0040, 16'hA000, 16'h0011, 0, 16'hB000, 16'h0011, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h1111, 16'h0040, 1, 16'h1111, 16'h0041, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0020, 16'hF000, 16'h0041, 1, 16'hB000, 16'h0041, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h2222, 16'h0020, 1, 16'h2222, 16'h0021, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'hFFFF, 16'h2222, 16'h0021, 1, 16'hB000, 16'h0021, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h3333, 16'hFFFF, 1, 16'h3333, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h4444, 16'h0000, 1, 16'h4444, 16'h0001, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h4444, 16'h0001, 0, 16'h4444, 16'h0001, 1, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 16'h4444, 16'h0001, 0, 16'hB000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h5555, 16'h0000, 1, 16'h5555, 16'h0001, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'hF123, 16'h0001, 1, 16'hF123, 16'h0002, 1, 1));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'hF123, 16'h0001, 0, 16'hB000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h6666, 16'h0000, 1, 16'h6666, 16'h0001, 1, 0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Halt must hold indefinitely whatever the memory presents.
    applyStimulus(mk(0, 0, 0, 16'h0000, 16'hF777, 16'h0001, 1, 16'hF777, 16'h0002, 1, 1));
    for (int k = 0; k < 6; k++) begin
      logic [15:0] junk;
      junk = 16'($urandom);
      applyStimulus(mk(0, k[0], 0, 16'h0000, junk, 16'h0001, 0, 16'hF777, 16'h0002, 1, 1));
    end
    applyStimulus(mk(0, 1, 1, 16'h0100, 16'h0000, 16'h0001, 0, 16'hB000, 16'h0002, 0, 0));
    applyStimulus(mk(0, 0, 0, 16'h0000, 16'h0ABC, 16'h0100, 1, 16'h0ABC, 16'h0101, 1, 0));

    if (sbQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
